// File: rtl/top_result_fifo.sv
// top_result_fifo: packs {bus_out, out0} into 3-bit words, buffers them in a
// small first-word-fall-through FIFO and hands them to a valid/ready consumer.
// Samples that arrive while the buffer is full are counted (saturating).
// With CHANGE_ONLY set, a sample equal to the last pushed word is skipped.
module top_result_fifo #(
    parameter int DATA_W      = 3,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     out0,
    input  logic [1:0]               bus_out,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Elaboration-time guards on the parameter set.
    if (DATA_W != 3) begin : g_badDataW
        $error("top_result_fifo: DATA_W must be 3");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
        $error("top_result_fifo: DEPTH must be a power of two and at least 2");
    end

    // Storage and bookkeeping state.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [DATA_W-1:0] r_doutHold;
    logic [DATA_W-1:0] r_lastWord;
    logic              r_lastValid;
    logic [CNT_W-1:0]  r_dropCnt;

    // Combinational decode of the current cycle.
    logic [DATA_W-1:0] w_word;
    logic              w_full;
    logic              w_empty;
    logic              w_qualify;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    assign w_word  = {bus_out, out0};
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);

    // Change-only mode skips a sample identical to the last word pushed;
    // the first sample after reset always qualifies.
    assign w_qualify = (CHANGE_ONLY == 1'b0) ? 1'b1
                     : (!r_lastValid || (w_word != r_lastWord));

    // in_ready comes only from registered level, so there is no path from
    // dout_ready to in_ready. A full FIFO therefore refuses a push even in
    // a cycle where the consumer pops.
    assign w_push = in_valid && !w_full && w_qualify;
    assign w_pop  = !w_empty && dout_ready;
    assign w_drop = in_valid && w_full && w_qualify;

    assign in_ready   = !w_full;
    assign dout_valid = !w_empty;
    assign level      = r_level;
    assign drop_cnt   = r_dropCnt;

    // Head word falls through while data is present; once drained, the last
    // word shown keeps being presented instead of a stale memory slot.
    assign dout = w_empty ? r_doutHold : r_mem[r_rptr];

    // Write side: store the packed word and advance the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= w_word;
            r_wptr        <= r_wptr + PTR_W'(1);
        end
    end

    // Read side: advance the read pointer and remember the word handed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr     <= '0;
            r_doutHold <= '0;
        end else if (w_pop) begin
            r_rptr     <= r_rptr + PTR_W'(1);
            r_doutHold <= r_mem[r_rptr];
        end
    end

    // Occupancy: full/empty are decided from this count, never from pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            r_level <= r_level - LVL_W'(1);
        end
    end

    // Last-pushed word tracking for change-only capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastWord  <= '0;
            r_lastValid <= 1'b0;
        end else if (CHANGE_ONLY && w_push) begin
            r_lastWord  <= w_word;
            r_lastValid <= 1'b1;
        end
    end

    // Saturating count of qualifying samples refused because the FIFO was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropCnt <= '0;
        end else if (w_drop && (r_dropCnt != '1)) begin
            r_dropCnt <= r_dropCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_top_result_fifo.sv
// tb_top_result_fifo: drives three configurations of top_result_fifo
// (default, change-only, 2-bit drop counter) from shared stimulus and
// compares their outputs against bench-side tables and a queue model.
module tb_top_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inValid;
    logic       out0;
    logic [1:0] busOut;
    logic       doutReady;

    logic       defInReady, defDoutValid;
    logic [2:0] defDout;
    logic [2:0] defLevel;
    logic [7:0] defDrop;

    logic       coInReady, coDoutValid;
    logic [2:0] coDout;
    logic [2:0] coLevel;
    logic [7:0] coDrop;

    logic       satInReady, satDoutValid;
    logic [2:0] satDout;
    logic [2:0] satLevel;
    logic [1:0] satDrop;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [2:0] w;
        logic       r;
        int         expLevel;
        logic       expInReady;
        logic       expDv;
        logic [2:0] expDout;
        int         expDrop;
    } vec_t;

    vec_t       vecs [14];
    logic [2:0] coSeq [6];
    logic [2:0] q [$];

    top_result_fifo u_dutDef (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .out0(out0), .bus_out(busOut),
        .in_ready(defInReady), .dout(defDout), .dout_valid(defDoutValid),
        .dout_ready(doutReady), .level(defLevel), .drop_cnt(defDrop)
    );

    top_result_fifo #(.CHANGE_ONLY(1'b1)) u_dutCo (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .out0(out0), .bus_out(busOut),
        .in_ready(coInReady), .dout(coDout), .dout_valid(coDoutValid),
        .dout_ready(doutReady), .level(coLevel), .drop_cnt(coDrop)
    );

    top_result_fifo #(.CNT_W(2)) u_dutSat (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .out0(out0), .bus_out(busOut),
        .in_ready(satInReady), .dout(satDout), .dout_valid(satDoutValid),
        .dout_ready(doutReady), .level(satLevel), .drop_cnt(satDrop)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after an edge, then moves to 1 unit
    // past the next edge so outputs reflect the sampled inputs.
    task automatic applyStimulus(input logic v, input logic [2:0] w, input logic r);
        inValid   = v;
        {busOut, out0} = w;
        doutReady = r;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        inValid   = 1'b0;
        {busOut, out0} = 3'd0;
        doutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         mLevel;
        int         pops;
        logic       pushOk, popOk, lastValid;
        logic [2:0] w, lastWord;

        vecs[0]  = '{1'b1, 3'd1, 1'b0, 1, 1'b1, 1'b1, 3'd1, 0};
        vecs[1]  = '{1'b1, 3'd6, 1'b0, 2, 1'b1, 1'b1, 3'd1, 0};
        vecs[2]  = '{1'b1, 3'd3, 1'b0, 3, 1'b1, 1'b1, 3'd1, 0};
        vecs[3]  = '{1'b1, 3'd4, 1'b0, 4, 1'b0, 1'b1, 3'd1, 0};
        vecs[4]  = '{1'b1, 3'd7, 1'b0, 4, 1'b0, 1'b1, 3'd1, 1};
        vecs[5]  = '{1'b1, 3'd2, 1'b0, 4, 1'b0, 1'b1, 3'd1, 2};
        vecs[6]  = '{1'b1, 3'd5, 1'b1, 3, 1'b1, 1'b1, 3'd6, 3};
        vecs[7]  = '{1'b0, 3'd0, 1'b1, 2, 1'b1, 1'b1, 3'd3, 3};
        vecs[8]  = '{1'b0, 3'd0, 1'b1, 1, 1'b1, 1'b1, 3'd4, 3};
        vecs[9]  = '{1'b0, 3'd0, 1'b1, 0, 1'b1, 1'b0, 3'd4, 3};
        vecs[10] = '{1'b0, 3'd0, 1'b1, 0, 1'b1, 1'b0, 3'd4, 3};
        vecs[11] = '{1'b1, 3'd5, 1'b0, 1, 1'b1, 1'b1, 3'd5, 3};
        vecs[12] = '{1'b1, 3'd2, 1'b1, 1, 1'b1, 1'b1, 3'd2, 3};
        vecs[13] = '{1'b0, 3'd0, 1'b1, 0, 1'b1, 1'b0, 3'd2, 3};

        coSeq[0] = 3'd5; coSeq[1] = 3'd5; coSeq[2] = 3'd5;
        coSeq[3] = 3'd2; coSeq[4] = 3'd2; coSeq[5] = 3'd5;

        // Reset state.
        resetDut();
        checkOutput("rst_level", int'(defLevel), 0);
        checkOutput("rst_in_ready", int'(defInReady), 1);
        checkOutput("rst_dout_valid", int'(defDoutValid), 0);
        checkOutput("rst_dout", int'(defDout), 0);
        checkOutput("rst_drop", int'(defDrop), 0);

        // Fill, overflow, pop-while-full, drain and simultaneous push/pop.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].v, vecs[i].w, vecs[i].r);
            checkOutput($sformatf("vec%0d_level", i), int'(defLevel), vecs[i].expLevel);
            checkOutput($sformatf("vec%0d_in_ready", i), int'(defInReady), int'(vecs[i].expInReady));
            checkOutput($sformatf("vec%0d_dout_valid", i), int'(defDoutValid), int'(vecs[i].expDv));
            checkOutput($sformatf("vec%0d_dout", i), int'(defDout), int'(vecs[i].expDout));
            checkOutput($sformatf("vec%0d_drop", i), int'(defDrop), vecs[i].expDrop);
        end

        // Streaming with consumer always ready; scoreboard tracks order.
        resetDut();
        mLevel = 0;
        q.delete();
        for (int c = 0; c < 20; c++) begin
            w = 3'(c % 8);
            checkOutput("stream_dout_valid", int'(defDoutValid), int'(mLevel != 0));
            if (mLevel != 0) begin
                checkOutput("stream_dout", int'(defDout), int'(q[0]));
            end
            pushOk = (mLevel < 4);
            popOk  = (mLevel > 0);
            applyStimulus(1'b1, w, 1'b1);
            if (popOk) void'(q.pop_front());
            if (pushOk) q.push_back(w);
            mLevel = mLevel + int'(pushOk) - int'(popOk);
            checkOutput("stream_level", int'(defLevel), mLevel);
        end
        checkOutput("stream_drop", int'(defDrop), 0);

        // Change-only capture: repeats are skipped and never counted as drops.
        resetDut();
        q.delete();
        lastValid = 1'b0;
        lastWord  = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!lastValid || (coSeq[i] != lastWord)) begin
                q.push_back(coSeq[i]);
                lastWord  = coSeq[i];
                lastValid = 1'b1;
            end
            applyStimulus(1'b1, coSeq[i], 1'b0);
        end
        checkOutput("co_level", int'(coLevel), 3);
        checkOutput("co_drop", int'(coDrop), 0);
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            if (coDoutValid && (q.size() > 0)) begin
                checkOutput($sformatf("co_pop%0d", pops), int'(coDout), int'(q.pop_front()));
                pops++;
            end
            applyStimulus(1'b0, 3'd0, 1'b1);
        end
        checkOutput("co_pop_count", pops, 3);
        checkOutput("co_level_drained", int'(coLevel), 0);

        // Narrow drop counter saturates and holds.
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'(i + 1), 1'b0);
        end
        checkOutput("sat_in_ready", int'(satInReady), 0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 3'd7, 1'b0);
            checkOutput($sformatf("sat_drop%0d", k), int'(satDrop), (k > 3) ? 3 : k);
        end
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("sat_drop_hold", int'(satDrop), 3);

        // Asynchronous reset in the middle of traffic.
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'(i + 1), 1'b0);
        end
        applyStimulus(1'b1, 3'd5, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1);
        checkOutput("mid_level_before", int'(defLevel), 3);
        checkOutput("mid_drop_before", int'(defDrop), 1);
        doutReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_dout_valid", int'(defDoutValid), 0);
        checkOutput("mid_rst_level", int'(defLevel), 0);
        checkOutput("mid_rst_in_ready", int'(defInReady), 1);
        checkOutput("mid_rst_drop", int'(defDrop), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd6, 1'b0);
        checkOutput("post_rst_dout", int'(defDout), 6);
        checkOutput("post_rst_dout_valid", int'(defDoutValid), 1);
        checkOutput("post_rst_level", int'(defLevel), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
